// File: rtl/conv1d_sweep_ctrl.sv
// conv1d_sweep_ctrl
//   Sequencer and arbiter in front of the conv1d CFU datapath. While idle, host
//   commands pass straight through to the datapath. A start pulse launches a
//   sweep over every output position x in [0, width): set window origin (42),
//   compute (41), read accumulator (43), then hand the result out on a
//   valid/ready port.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   start, abort      begin a sweep / cancel the sweep in progress
//   width             number of output positions (sampled on accepted start)
//   busy, done        sweep active (registered) / one-cycle completion pulse
//   out_data/index    result accumulator and its position, out_valid/out_ready
//   host_*            host command port; host_reject pulses on dropped commands
//   dp_*              datapath command port and its registered result dp_ret
module conv1d_sweep_ctrl #(
  parameter int INT32_SIZE = 32,
  parameter int PAD_LEFT   = 4,
  parameter int X_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [X_WIDTH-1:0]    width,
  output logic                  busy,
  output logic                  done,
  output logic [INT32_SIZE-1:0] out_data,
  output logic [X_WIDTH-1:0]    out_index,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  host_en,
  input  logic [6:0]            host_cmd,
  input  logic [INT32_SIZE-1:0] host_inp0,
  input  logic [INT32_SIZE-1:0] host_inp1,
  output logic [INT32_SIZE-1:0] host_ret,
  output logic                  host_reject,
  output logic                  dp_en,
  output logic [6:0]            dp_cmd,
  output logic [INT32_SIZE-1:0] dp_inp0,
  output logic [INT32_SIZE-1:0] dp_inp1,
  input  logic [INT32_SIZE-1:0] dp_ret
);

  localparam logic [6:0] CMD_COMPUTE = 7'd41;
  localparam logic [6:0] CMD_ORIGIN  = 7'd42;
  localparam logic [6:0] CMD_READ    = 7'd43;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ORIGIN, ST_COMPUTE, ST_READ, ST_CAPTURE, ST_OUT, ST_DONE
  } state_t;

  state_t               state, state_next;
  logic [X_WIDTH-1:0]   x;
  logic [X_WIDTH-1:0]   width_q;
  logic                 last_pos;
  logic                 handshake;

  // Window origin in 32-bit signed so positions left of the padding go negative.
  function automatic logic signed [INT32_SIZE-1:0] origin_of(input logic [X_WIDTH-1:0] xv);
    return $signed(INT32_SIZE'(xv)) - $signed(INT32_SIZE'(PAD_LEFT));
  endfunction

  // width_q is non-zero whenever this is consulted, so width_q-1 never wraps and
  // x stops at width_q-1 before it could overflow.
  assign last_pos  = (x == width_q - X_WIDTH'(1));
  assign handshake = out_valid && out_ready;
  assign host_ret  = dp_ret;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    dp_en      = 1'b0;
    dp_cmd     = '0;
    dp_inp0    = '0;
    dp_inp1    = '0;
    case (state)
      ST_IDLE: begin
        dp_en   = host_en;
        dp_cmd  = host_cmd;
        dp_inp0 = host_inp0;
        dp_inp1 = host_inp1;
        if (start) state_next = (width == '0) ? ST_DONE : ST_ORIGIN;
      end
      ST_ORIGIN: begin
        dp_en      = 1'b1;
        dp_cmd     = CMD_ORIGIN;
        dp_inp1    = origin_of(x);
        state_next = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        dp_en      = 1'b1;
        dp_cmd     = CMD_COMPUTE;
        state_next = ST_READ;
      end
      ST_READ: begin
        dp_en      = 1'b1;
        dp_cmd     = CMD_READ;
        state_next = ST_CAPTURE;
      end
      ST_CAPTURE: state_next = ST_OUT;
      ST_OUT: begin
        if (handshake) state_next = last_pos ? ST_DONE : ST_ORIGIN;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    // Abort only redirects the state; a command already on dp_* this cycle stands.
    if (abort && state != ST_IDLE) state_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      host_reject <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_index   <= '0;
      x           <= '0;
      width_q     <= '0;
    end else begin
      busy        <= (state_next != ST_IDLE);
      done        <= (state_next == ST_DONE);
      host_reject <= host_en && (state != ST_IDLE);
      if (state == ST_IDLE && start) begin
        width_q <= width;
        x       <= '0;
      end
      if (state == ST_CAPTURE) begin
        out_data  <= dp_ret;
        out_index <= x;
        out_valid <= 1'b1;
      end
      if (state == ST_OUT && handshake) begin
        out_valid <= 1'b0;
        if (!last_pos) x <= x + X_WIDTH'(1);
      end
      if (abort && state != ST_IDLE) out_valid <= 1'b0;
    end
  end

endmodule
